// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin scheduler that shares a single uart_tx among NUM_REQ byte
// producers. One byte is accepted per grant. The block drives the uart_tx
// write strobe and write_value. uart_tx has no busy output, so this block
// times every frame itself. It holds off the next grant until the frame
// time has elapsed.
//
// Ports
//   clk_50M      system clock (single domain)
//   reset_n      asynchronous active-low reset
//   req_valid    per-requester "byte pending"
//   req_data     byte of requester i on [8i+7:8i]
//   req_ready    one-cycle accept pulse, at most one bit set
//   write        strobe to uart_tx, WRITE_CLKS cycles wide
//   write_value  byte to uart_tx, held for the whole frame
//   busy         a frame is in progress
//   grant_id     index of the last granted requester
//   frame_count  (only with UART_TX_SCHED_STATS_EN) grants since reset, mod 2^16
//
// Optional feature macro: UART_TX_SCHED_STATS_EN
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | line free, arbitrate among valid requesters
// STROBE | write strobe high, frame timer running
// HOLD   | strobe done, waiting for the frame time to elapse

module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int GUARD_BITS = 1,
    parameter int WRITE_CLKS = 4
) (
    input  logic                 clk_50M,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 write,
    output logic [7:0]           write_value,
    output logic                 busy,
    output logic [2:0]           grant_id
`ifdef UART_TX_SCHED_STATS_EN
    ,
    output logic [15:0]          frame_count
`endif
);

    localparam int BIT_CLKS   = CLK_HZ / BAUD;
    localparam int FRAME_CLKS = (10 + GUARD_BITS) * BIT_CLKS;
    // One spare bit so the timer can never wrap inside a frame.
    localparam int CNT_W      = $clog2(FRAME_CLKS + 1) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [2:0]         last, last_d;
    logic [NUM_REQ-1:0] req_ready_d;
    logic               write_d;
    logic [7:0]         write_value_d;
    logic               busy_d;
    logic [2:0]         grant_id_d;

    logic [7:0]         valid_ext;
    logic [63:0]        data_ext;
    logic [3:0]         cand;
    logic               win_found;
    logic [2:0]         win_idx;
    logic               frame_end;
    logic               strobe_end;
    logic               line_free;
    logic               grant;

    // Widen to the 8-requester maximum so a 3-bit index always fits exactly.
    assign valid_ext  = 8'(req_valid);
    assign data_ext   = 64'(req_data);

    assign strobe_end = (state == STROBE) && (cnt == CNT_W'(WRITE_CLKS));
    assign frame_end  = (state == HOLD) && (cnt == CNT_W'(FRAME_CLKS));
    // The cycle in which the frame time expires already counts as line-free.
    // This lets a waiting request win exactly FRAME_CLKS after the previous
    // write rise.
    assign line_free  = (state == IDLE) || frame_end;
    assign grant      = line_free && win_found;

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 4'(last) + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!win_found && valid_ext[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= 3'(NUM_REQ - 1);
            req_ready   <= '0;
            write       <= 1'b0;
            write_value <= 8'h00;
            busy        <= 1'b0;
            grant_id    <= 3'd0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            last        <= last_d;
            req_ready   <= req_ready_d;
            write       <= write_d;
            write_value <= write_value_d;
            busy        <= busy_d;
            grant_id    <= grant_id_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (grant) state_d = STROBE;
            STROBE:  if (strobe_end) state_d = HOLD;
            HOLD:    if (frame_end) state_d = grant ? STROBE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_d   = '0;
        write_d       = 1'b0;
        write_value_d = write_value;
        busy_d        = busy;
        grant_id_d    = grant_id;
        last_d        = last;
        cnt_d         = cnt + CNT_W'(1);
        if (grant) begin
            req_ready_d   = NUM_REQ'(1) << win_idx;
            write_d       = 1'b1;
            write_value_d = data_ext[{win_idx, 3'b000} +: 8];
            busy_d        = 1'b1;
            grant_id_d    = win_idx;
            last_d        = win_idx;
            cnt_d         = CNT_W'(1);
        end else begin
            if ((state == STROBE) && !strobe_end) begin
                write_d = 1'b1;
            end
            if (frame_end) begin
                busy_d = 1'b0;
            end
            if (state_d == IDLE) begin
                cnt_d = '0;
            end
        end
    end

`ifdef UART_TX_SCHED_STATS_EN
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= 16'h0000;
        end else if (grant) begin
            frame_count <= frame_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched. The bench uses a short frame so the whole run
// stays small: BIT_CLKS=10 and FRAME_CLKS=110.
// A reference model keeps the time of the last grant and the round-robin
// pointer. It pushes the expected grants into a queue. A monitor pops that
// queue whenever req_ready shows up. It also checks busy, write, write_value
// and grant_id every cycle.

module tb_uart_tx_sched;

    localparam int NR     = 4;
    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int GUARD  = 1;
    localparam int WCLK   = 4;
    localparam int F      = (10 + GUARD) * (CLK_HZ / BAUD);

    logic            clk_50M = 1'b0;
    logic            reset_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            write;
    logic [7:0]      write_value;
    logic            busy;
    logic [2:0]      grant_id;
`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0]     frame_count;
`endif

    uart_tx_sched #(
        .NUM_REQ    (NR),
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .GUARD_BITS (GUARD),
        .WRITE_CLKS (WCLK)
    ) dut (
        .clk_50M     (clk_50M),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .write       (write),
        .write_value (write_value),
        .busy        (busy),
        .grant_id    (grant_id)
`ifdef UART_TX_SCHED_STATS_EN
        ,
        .frame_count (frame_count)
`endif
    );

    always #10 clk_50M = ~clk_50M;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         cyc;
    } grant_t;

    grant_t     exp_q[$];
    int         grant_log[$];
    logic [7:0] data_log[$];

    // Reference model: a grant is legal once F edges have passed since the
    // last one. The winner is the first valid index after the previous winner.
    int          cyc = 0;
    int          last_m = NR - 1;
    int          g_cyc = 0;
    bit          have_g = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_write = 1'b0;
    logic [7:0]  exp_wv = 8'h00;
    int          exp_gid = 0;
    logic [15:0] frames = 16'h0000;
    int          w_m;
    int          c_m;

    always @(posedge clk_50M) begin
        cyc++;
        if (!reset_n) begin
            last_m    = NR - 1;
            have_g    = 1'b0;
            exp_busy  = 1'b0;
            exp_write = 1'b0;
            exp_wv    = 8'h00;
            exp_gid   = 0;
            frames    = 16'h0000;
            exp_q.delete();
        end else begin
            if ((req_valid != '0) && (!have_g || (cyc - g_cyc >= F))) begin
                w_m = -1;
                for (int k = 1; k <= NR; k++) begin
                    c_m = (last_m + k) % NR;
                    if (w_m < 0 && req_valid[c_m]) w_m = c_m;
                end
                exp_q.push_back('{idx: w_m, data: req_data[8*w_m +: 8], cyc: cyc});
                last_m  = w_m;
                g_cyc   = cyc;
                have_g  = 1'b1;
                exp_wv  = req_data[8*w_m +: 8];
                exp_gid = w_m;
                frames  = frames + 16'h0001;
            end
            exp_busy  = have_g && (cyc - g_cyc < F);
            exp_write = have_g && (cyc - g_cyc < WCLK);
        end
    end

    grant_t g_pop;

    always @(negedge clk_50M) begin
        if (reset_n) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("write", 32'(write), 32'(exp_write));
            chk("write_value", 32'(write_value), 32'(exp_wv));
            chk("grant_id", 32'(grant_id), 32'(exp_gid));
`ifdef UART_TX_SCHED_STATS_EN
            chk("frame_count", 32'(frame_count), 32'(frames));
`endif
            if (req_ready != '0) begin
                chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                grant_log.push_back(int'(grant_id));
                data_log.push_back(write_value);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant actual=%b required=none (t=%0t)", req_ready, $time);
                end else begin
                    g_pop = exp_q.pop_front();
                    chk("ready_idx", 32'(req_ready), 32'd1 << g_pop.idx);
                    chk("grant_cycle", 32'(cyc), 32'(g_pop.cyc));
                    chk("grant_data", 32'(write_value), 32'(g_pop.data));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                g_pop = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_grant actual=none required=req%0d (t=%0t)", g_pop.idx, $time);
            end
        end
    end

    bit keep_mode = 1'b0;
    bit rand_mode = 1'b0;

    // Advance n cycles. Producers react to req_ready at each falling edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_50M);
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i] && reset_n) begin
                    if (rand_mode && ($urandom_range(0, 1) == 1)) begin
                        req_data[8*i +: 8] = 8'($urandom);
                    end else if (!keep_mode) begin
                        req_valid[i] = 1'b0;
                    end
                end else if (rand_mode) begin
                    if (!req_valid[i] && ($urandom_range(0, 39) == 0)) begin
                        req_data[8*i +: 8] = 8'($urandom);
                        req_valid[i] = 1'b1;
                    end else if (req_valid[i] && ($urandom_range(0, 299) == 0)) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d);
        req_data[8*i +: 8] = d;
        req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        step(2);
        reset_n   = 1'b1;
    endtask

    initial begin
        #1;
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_write_value", 32'(write_value), 32'd0);
        step(3);
        reset_n = 1'b1;

        // single request
        set_req(0, 8'h21);
        step(F + 20);

        // contention straight after reset: req0 wins, req2 follows one frame later
        do_reset();
        grant_log.delete();
        data_log.delete();
        set_req(0, 8'h43);
        set_req(2, 8'h65);
        step(2 * F + 20);
        chk("cont_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            chk("cont_first", 32'(grant_log[0]), 32'd0);
            chk("cont_second", 32'(grant_log[1]), 32'd2);
            chk("cont_byte1", 32'(data_log[1]), 32'h65);
        end

        // fairness with every requester continuously valid
        do_reset();
        grant_log.delete();
        data_log.delete();
        keep_mode = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 8'(8'h10 + i));
        step(4 * F + 10);
        keep_mode = 1'b0;
        req_valid = '0;
        step(F + 5);
        chk("fair_count", 32'(grant_log.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) begin
                chk("fair_order", 32'(grant_log[k]), 32'(k % NR));
                chk("fair_byte", 32'(data_log[k]), 32'(8'h10 + (k % NR)));
            end
        end

        // withdrawal during a frame
        grant_log.delete();
        set_req(0, 8'h5A);
        step(30);
        set_req(1, 8'h66);
        step(50);
        req_valid[1] = 1'b0;
        step(2 * F);
        chk("withdraw_grants", 32'(grant_log.size()), 32'd1);
        chk("withdraw_busy", 32'(busy), 32'd0);

        // reset in the middle of HOLD
        set_req(0, 8'h99);
        step(60);
        #2;
        reset_n   = 1'b0;
        req_valid = '0;
        #1;
        chk("midrst_write", 32'(write), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_grant_id", 32'(grant_id), 32'd0);
        step(3);
        reset_n = 1'b1;
        set_req(3, 8'h77);
        step(1);
        chk("midrst_ready3", 32'(req_ready), 32'h8);
        chk("midrst_gid3", 32'(grant_id), 32'd3);
        step(F + 10);

        // randomized traffic with withdrawals
        rand_mode = 1'b1;
        step(3000);
        rand_mode = 1'b0;
        req_valid = '0;
        step(F + 10);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_grants actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
